fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_addsub_pipe.sv | 197 +++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor: truncating, saturating on overflow,
// flushing to zero on underflow, valid/ready handshake with a whole-pipeline stall.
module fp_addsub_pipe #(
    parameter int EW = 4,
    parameter int MW = 7,
    localparam int W = 1 + EW + MW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic         ovf,
    output logic         unf
);
    localparam int EXW = EW + 2;
    localparam int LZW = $clog2(MW + 2);
    localparam logic signed [EXW-1:0] EXP_MAX = EXW'((1 << EW) - 1);
    localparam logic signed [EXW-1:0] EXP_MIN = EXW'(1);

    logic                  advance_s;
    logic                  x_zero_s, y_zero_s, y_sign_s, swap_s;
    logic                  a_sign_s, b_sign_s;
    logic [EW-1:0]         a_exp_s, b_exp_s;
    logic [MW-1:0]         a_man_s, b_man_s;
    logic [W-1:0]          byp_val_s;

    logic                  v1_r, s1_sign_r, s1_eff_sub_r, s1_byp_r;
    logic [EW-1:0]         s1_exp_r, s1_d_r;
    logic [MW:0]           s1_sig_a_r, s1_sig_b_r;
    logic [W-1:0]          s1_byp_val_r;

    logic [MW:0]           b_shift_s;
    logic [MW+1:0]         sum_s;
    logic                  v2_r, s2_sign_r, s2_byp_r;
    logic [EW-1:0]         s2_exp_r;
    logic [MW+1:0]         s2_sum_r;
    logic [W-1:0]          s2_byp_val_r;

    logic [LZW-1:0]        lz_s;
    logic [MW-1:0]         man_n_s;
    logic signed [EXW-1:0] exp_n_s;
    logic [W-1:0]          z_n_s;
    logic                  ovf_n_s, unf_n_s;
    logic                  v3_r, ovf_r, unf_r;
    logic [W-1:0]          z_r;

    // The whole pipeline moves together; it only freezes when the output is held.
    assign advance_s = ~v3_r | out_ready;
    assign in_ready  = advance_s;
    assign out_valid = v3_r;
    assign z         = z_r;
    assign ovf       = ovf_r;
    assign unf       = unf_r;

    // Stage 1: effective sign of y, magnitude ordering (tie keeps x as A), zero bypass.
    always_comb begin
        x_zero_s = (x[W-2:MW] == {EW{1'b0}});
        y_zero_s = (y[W-2:MW] == {EW{1'b0}});
        y_sign_s = y[W-1] ^ sub;
        swap_s   = (y[W-2:0] > x[W-2:0]);
        if (swap_s) begin
            a_sign_s = y_sign_s;
            a_exp_s  = y[W-2:MW];
            a_man_s  = y[MW-1:0];
            b_sign_s = x[W-1];
            b_exp_s  = x[W-2:MW];
            b_man_s  = x[MW-1:0];
        end else begin
            a_sign_s = x[W-1];
            a_exp_s  = x[W-2:MW];
            a_man_s  = x[MW-1:0];
            b_sign_s = y_sign_s;
            b_exp_s  = y[W-2:MW];
            b_man_s  = y[MW-1:0];
        end
        if (x_zero_s && y_zero_s) begin
            byp_val_s = {W{1'b0}};
        end else if (x_zero_s) begin
            byp_val_s = {y_sign_s, y[W-2:0]};
        end else if (y_zero_s) begin
            byp_val_s = x;
        end else begin
            byp_val_s = {W{1'b0}};
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r         <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_eff_sub_r <= 1'b0;
            s1_byp_r     <= 1'b0;
            s1_exp_r     <= {EW{1'b0}};
            s1_d_r       <= {EW{1'b0}};
            s1_sig_a_r   <= {(MW+1){1'b0}};
            s1_sig_b_r   <= {(MW+1){1'b0}};
            s1_byp_val_r <= {W{1'b0}};
        end else if (advance_s) begin
            v1_r         <= in_valid;
            s1_sign_r    <= a_sign_s;
            s1_eff_sub_r <= a_sign_s ^ b_sign_s;
            s1_byp_r     <= x_zero_s | y_zero_s;
            s1_exp_r     <= a_exp_s;
            s1_d_r       <= a_exp_s - b_exp_s;
            s1_sig_a_r   <= {1'b1, a_man_s};
            s1_sig_b_r   <= {1'b1, b_man_s};
            s1_byp_val_r <= byp_val_s;
        end
    end

    // Stage 2: align B by truncating right shift, then add or subtract magnitudes.
    always_comb begin
        if (s1_d_r > EW'(MW)) begin
            b_shift_s = {(MW+1){1'b0}};
        end else begin
            b_shift_s = s1_sig_b_r >> s1_d_r;
        end
        if (s1_eff_sub_r) begin
            sum_s = {1'b0, s1_sig_a_r} - {1'b0, b_shift_s};
        end else begin
            sum_s = {1'b0, s1_sig_a_r} + {1'b0, b_shift_s};
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r         <= 1'b0;
            s2_sign_r    <= 1'b0;
            s2_byp_r     <= 1'b0;
            s2_exp_r     <= {EW{1'b0}};
            s2_sum_r     <= {(MW+2){1'b0}};
            s2_byp_val_r <= {W{1'b0}};
        end else if (advance_s) begin
            v2_r         <= v1_r;
            s2_sign_r    <= s1_sign_r;
            s2_byp_r     <= s1_byp_r;
            s2_exp_r     <= s1_exp_r;
            s2_sum_r     <= sum_s;
            s2_byp_val_r <= s1_byp_val_r;
        end
    end

    // Stage 3: normalise, then pick bypass / cancellation / saturation / flush / normal result.
    always_comb begin
        lz_s = LZW'(MW + 1);
        for (int i = 0; i <= MW; i++) begin
            lz_s = s2_sum_r[i] ? LZW'(MW - i) : lz_s;
        end
        if (s2_sum_r[MW+1]) begin
            man_n_s = s2_sum_r[MW:1];
            exp_n_s = $signed({2'b00, s2_exp_r}) + EXP_MIN;
        end else begin
            man_n_s = s2_sum_r[MW-1:0] << lz_s;
            exp_n_s = $signed({2'b00, s2_exp_r}) - $signed(EXW'(lz_s));
        end
        z_n_s   = {W{1'b0}};
        ovf_n_s = 1'b0;
        unf_n_s = 1'b0;
        if (!v2_r) begin
            z_n_s = {W{1'b0}};
        end else if (s2_byp_r) begin
            z_n_s = s2_byp_val_r;
        end else if (s2_sum_r == {(MW+2){1'b0}}) begin
            z_n_s = {W{1'b0}};
        end else if (exp_n_s > EXP_MAX) begin
            z_n_s   = {s2_sign_r, {(W-1){1'b1}}};
            ovf_n_s = 1'b1;
        end else if (exp_n_s < EXP_MIN) begin
            unf_n_s = 1'b1;
        end else begin
            z_n_s = {s2_sign_r, exp_n_s[EW-1:0], man_n_s};
        end
    end

    // Stage 3 register drives the outputs; a bubble clears z/ovf/unf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_r  <= 1'b0;
            z_r   <= {W{1'b0}};
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (advance_s) begin
            v3_r  <= v2_r;
            z_r   <= z_n_s;
            ovf_r <= ovf_n_s;
            unf_r <= unf_n_s;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe: directed vectors, randomized streaming with
// random back-pressure against an arithmetic reference model, stall and reset scenarios.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready, ovf, unf;
    logic [11:0] x, y, z;
    int          checks = 0;
    int          errors = 0;
    logic [13:0] q[$];

    logic [11:0] dx [0:7] = '{12'h280, 12'h280, 12'h280, 12'h280, 12'h7FF, 12'h0C0, 12'h000, 12'h280};
    logic [11:0] dy [0:7] = '{12'h280, 12'h080, 12'h080, 12'h280, 12'h7FF, 12'h080, 12'h280, 12'h000};
    logic        ds [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [11:0] dz [0:7] = '{12'h300, 12'h288, 12'h270, 12'h000, 12'h7FF, 12'h000, 12'hA80, 12'h280};
    logic        dov[0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        dun[0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    fp_addsub_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Value model: significands as integers scaled by 2^(exp-7); returns {ovf, unf, z}.
    function automatic logic [13:0] model(input logic [11:0] a, input logic [11:0] b, input logic s);
        logic sb, sgn_a, sgn_b;
        int   ea, eb, sig_a, sig_b, r, e;
        sb = b[11] ^ s;
        if (a[10:7] == 4'h0 && b[10:7] == 4'h0) return 14'h0000;
        if (a[10:7] == 4'h0) return {2'b00, sb, b[10:0]};
        if (b[10:7] == 4'h0) return {2'b00, a};
        if (b[10:0] > a[10:0]) begin
            sgn_a = sb;    sgn_b = a[11];
            ea = int'(b[10:7]); eb = int'(a[10:7]);
            sig_a = 128 + int'(b[6:0]); sig_b = 128 + int'(a[6:0]);
        end else begin
            sgn_a = a[11]; sgn_b = sb;
            ea = int'(a[10:7]); eb = int'(b[10:7]);
            sig_a = 128 + int'(a[6:0]); sig_b = 128 + int'(b[6:0]);
        end
        sig_b = sig_b >> (ea - eb);
        r = (sgn_a == sgn_b) ? sig_a + sig_b : sig_a - sig_b;
        if (r == 0) return 14'h0000;
        e = ea;
        while (r >= 256) begin r = r >> 1; e++; end
        while (r < 128) begin r = r << 1; e--; end
        if (e > 15) return {2'b10, sgn_a, 11'h7FF};
        if (e < 1) return {2'b01, 12'h000};
        return {2'b00, sgn_a, 4'(e), 7'(r)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = 12'h000; y = 12'h000; sub = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || z !== 12'h000 || ovf !== 1'b0 || unf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b z=%h ovf=%b unf=%b in_ready=%b, need 0 000 0 0 1",
                     out_valid, z, ovf, unf, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || z !== 12'h000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: out_valid=%b z=%h in_ready=%b", out_valid, z, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        int cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; x = dx[i]; y = dy[i]; sub = ds[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir_in_ready[%0d]: got %b need 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            cnt = 0;
            while (out_valid !== 1'b1 && cnt < 10) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            // out_valid rises on the third rising edge counting the accepting edge.
            checks++;
            if (cnt != 2) begin
                errors++;
                $display("FAIL dir_latency[%0d]: edges after accept %0d, need 2", i, cnt);
            end
            checks++;
            if (z !== dz[i] || ovf !== dov[i] || unf !== dun[i]) begin
                errors++;
                $display("FAIL dir_result[%0d]: z=%h ovf=%b unf=%b, need z=%h ovf=%b unf=%b",
                         i, z, ovf, unf, dz[i], dov[i], dun[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [13:0] exp_v;
        logic [11:0] held_z;
        logic        held_o, held_u, stall_prev;
        int          mode, cnt;
        q.delete();
        stall_prev = 1'b0;
        held_z = 12'h000; held_o = 1'b0; held_u = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || z !== held_z || ovf !== held_o || unf !== held_u) begin
                    errors++;
                    $display("FAIL rnd_stall_hold: v=%b z=%h ovf=%b unf=%b, need 1 %h %b %b",
                             out_valid, z, ovf, unf, held_z, held_o, held_u);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sub  = 1'($urandom_range(0, 1));
            x    = 12'($urandom);
            mode = $urandom_range(0, 5);
            case (mode)
                0: y = {1'($urandom), 4'h0, 7'($urandom)};
                1: y = {~x[11], x[10:0]};
                2: y = x;
                3: y = {1'($urandom), x[10:7], 7'($urandom)};
                4: begin y = 12'($urandom); x = {x[11], 4'h0, x[6:0]}; end
                default: y = 12'($urandom);
            endcase
            #1;
            if (out_valid !== 1'b1) begin
                checks++;
                if (ovf !== 1'b0 || unf !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_flags_idle: ovf=%b unf=%b need 0 0", ovf, unf);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_unexpected: z=%h with no result pending", z);
                end else begin
                    exp_v = q.pop_front();
                    if ({ovf, unf, z} !== exp_v) begin
                        errors++;
                        $display("FAIL rnd_result: ovf=%b unf=%b z=%h, need ovf=%b unf=%b z=%h",
                                 ovf, unf, z, exp_v[13], exp_v[12], exp_v[11:0]);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) q.push_back(model(x, y, sub));
            stall_prev = (out_valid === 1'b1) && !out_ready;
            held_z = z; held_o = ovf; held_u = unf;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cnt = 0;
        while (q.size() > 0 && cnt < 20) begin
            if (out_valid === 1'b1) begin
                exp_v = q.pop_front();
                checks++;
                if ({ovf, unf, z} !== exp_v) begin
                    errors++;
                    $display("FAIL rnd_drain: ovf=%b unf=%b z=%h, need ovf=%b unf=%b z=%h",
                             ovf, unf, z, exp_v[13], exp_v[12], exp_v[11:0]);
                end
            end
            @(posedge clk);
            #1;
            cnt++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain_timeout: %0d results missing", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp_v;
        logic [11:0] held_z;
        logic        stall_prev, saw_stall;
        int          sent, got;
        q.delete();
        sent = 0; got = 0; stall_prev = 1'b0; saw_stall = 1'b0; held_z = 12'h000;
        x = 12'($urandom); y = 12'($urandom); sub = 1'($urandom_range(0, 1));
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || z !== held_z) begin
                    errors++;
                    $display("FAIL b2b_hold[%0d]: v=%b z=%h need 1 %h", cyc, out_valid, z, held_z);
                end
            end
            in_valid  = (sent < 6);
            out_ready = !(cyc >= 4 && cyc <= 8);
            #1;
            if (out_valid === 1'b1 && !out_ready) begin
                saw_stall = 1'b1;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_in_ready[%0d]: got %b need 0 while stalled", cyc, in_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                got++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: z=%h beyond the 6 results", z);
                end else begin
                    exp_v = q.pop_front();
                    if ({ovf, unf, z} !== exp_v) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: z=%h ovf=%b unf=%b need z=%h ovf=%b unf=%b",
                                 got, z, ovf, unf, exp_v[11:0], exp_v[13], exp_v[12]);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(model(x, y, sub));
                sent++;
            end
            stall_prev = (out_valid === 1'b1) && !out_ready;
            held_z = z;
            @(posedge clk);
            #1;
            if (in_valid && q.size() + got == sent) begin
                x = 12'($urandom); y = 12'($urandom); sub = 1'($urandom_range(0, 1));
            end
            if (sent == 6 && got == 6) break;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 6 || q.size() != 0 || saw_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count: delivered %0d pending %0d stalled %b, need 6 0 1", got, q.size(), saw_stall);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        int cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; x = 12'($urandom) | 12'h100; y = 12'h280; sub = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_fill: out_valid=%b need 1 with pipeline full", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || z !== 12'h000 || ovf !== 1'b0 || unf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: out_valid=%b z=%h ovf=%b unf=%b in_ready=%b, need 0 000 0 0 1",
                     out_valid, z, ovf, unf, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale[%0d]: out_valid=%b z=%h need 0", i, out_valid, z);
            end
        end
        in_valid = 1'b1; x = 12'h280; y = 12'h080; sub = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checks++;
        if (out_valid !== 1'b1 || z !== 12'h288 || cnt != 2) begin
            errors++;
            $display("FAIL rst_mid_first: v=%b z=%h edges %0d, need 1 288 2", out_valid, z, cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_dup: out_valid=%b z=%h need 0", out_valid, z);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
